// File: rtl/vecmul_feeder.sv
// Gathers (a,b) float32 pairs into VSIZE-lane operand vectors, drives vecmul for a
// fixed pipeline latency, and returns the captured dot product on a valid/ready port.
module vecmul_feeder #(
    parameter int VSIZE    = 4,
    parameter int PIPE_LAT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_a,
    input  logic [31:0]           s_b,
    input  logic                  s_last,
    output logic [VSIZE*32-1:0]   vm_in1,
    output logic [VSIZE*32-1:0]   vm_in2,
    output logic                  vm_en,
    input  logic [31:0]           vm_result,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_data,
    output logic [15:0]           vec_count
);
    localparam int IW = (VSIZE > 1) ? $clog2(VSIZE) : 1;
    localparam int CW = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t                     r_state;
    logic [IW-1:0]              r_idx;
    logic [VSIZE-1:0][31:0]     r_in1;
    logic [VSIZE-1:0][31:0]     r_in2;
    logic                       r_en;
    logic                       r_s_ready;
    logic                       r_m_valid;
    logic [31:0]                r_m_data;
    logic [CW-1:0]              r_cnt;
    logic [15:0]                r_vec_count;
    logic                       w_accept;
    logic                       w_close;

    assign w_accept = s_valid && r_s_ready;
    // A vector closes on its last lane or on an early s_last; short vectors keep zero padding.
    assign w_close  = s_last || (r_idx == IW'(VSIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_idx       <= '0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_en        <= 1'b0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_cnt       <= '0;
            r_vec_count <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_in1[r_idx] <= s_a;
                        r_in2[r_idx] <= s_b;
                        r_idx        <= r_idx + IW'(1);
                        if (w_close) begin
                            r_state   <= S_ISSUE;
                            r_s_ready <= 1'b0;
                            r_en      <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CW'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == CW'(PIPE_LAT)) begin
                        r_m_data  <= vm_result;
                        r_m_valid <= 1'b1;
                        r_en      <= 1'b0;
                        r_state   <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        r_m_valid   <= 1'b0;
                        r_vec_count <= r_vec_count + 16'd1;
                        r_in1       <= '0;
                        r_in2       <= '0;
                        r_idx       <= '0;
                        r_s_ready   <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign vm_in1    = r_in1;
    assign vm_in2    = r_in2;
    assign vm_en     = r_en;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign vec_count = r_vec_count;
endmodule
